// File: rtl/microseq_next_state.sv
// -----------------------------------------------------------------------------
// microseq_next_state
//
// Next-state sequencer for the microprogrammed control unit. Holds the current
// control-state register and selects the next state every cycle from one of:
// increment, opcode dispatch, direct jump, conditional jump, fetch return, or
// microsubroutine call/return through an internal LIFO return stack. The
// sequencer freezes while the current microinstruction waits for memory.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   ns_mode        next-state mode (INC, DISPATCH, JUMP, CJUMP, FETCH, CALL,
//                  RET, HOLD)
//   jump_state     jump/call target from the microstore
//   dispatch_state target from the instruction state encoder
//   cond           datapath condition flags
//   cond_sel       selects the tested condition (out-of-range reads as 0)
//   cond_inv       inverts the selected condition
//   mem_wait       current microinstruction waits for moc
//   moc            memory operation complete
//   state          current control state (registered)
//   stack_depth    occupied return-stack entries (registered)
//   waiting        combinational stall indication: mem_wait & ~moc
//   illegal_op     registered one-cycle pulse on illegal dispatch
//   stack_ovf      sticky return-stack overflow flag
//   stack_unf      sticky return-stack underflow flag
// -----------------------------------------------------------------------------
module microseq_next_state #(
    parameter int STATE_W     = 7,
    parameter int NUM_COND    = 4,
    parameter int STACK_DEPTH = 4,
    parameter int FETCH_STATE = 0,
    parameter int RESET_STATE = 0,
    localparam int COND_SEL_W = (NUM_COND > 1) ? $clog2(NUM_COND) : 1,
    localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            ns_mode,
    input  logic [STATE_W-1:0]    jump_state,
    input  logic [STATE_W-1:0]    dispatch_state,
    input  logic [NUM_COND-1:0]   cond,
    input  logic [COND_SEL_W-1:0] cond_sel,
    input  logic                  cond_inv,
    input  logic                  mem_wait,
    input  logic                  moc,
    output logic [STATE_W-1:0]    state,
    output logic [DEPTH_W-1:0]    stack_depth,
    output logic                  waiting,
    output logic                  illegal_op,
    output logic                  stack_ovf,
    output logic                  stack_unf
);

    localparam logic [2:0] MODE_INC      = 3'd0;
    localparam logic [2:0] MODE_DISPATCH = 3'd1;
    localparam logic [2:0] MODE_JUMP     = 3'd2;
    localparam logic [2:0] MODE_CJUMP    = 3'd3;
    localparam logic [2:0] MODE_FETCH    = 3'd4;
    localparam logic [2:0] MODE_CALL     = 3'd5;
    localparam logic [2:0] MODE_RET      = 3'd6;
    localparam logic [2:0] MODE_HOLD     = 3'd7;

    localparam logic [STATE_W-1:0] FETCH_S = STATE_W'(FETCH_STATE);
    localparam logic [STATE_W-1:0] RESET_S = STATE_W'(RESET_STATE);
    localparam logic [DEPTH_W-1:0] FULL_D  = DEPTH_W'(STACK_DEPTH);

    // Registered state
    logic [STATE_W-1:0] state_r;
    logic [DEPTH_W-1:0] depth_r;
    logic [STATE_W-1:0] stack_r [STACK_DEPTH];
    logic               illegal_r;
    logic               ovf_r;
    logic               unf_r;

    // Combinational decision signals
    logic [STATE_W-1:0] inc_s;
    logic [STATE_W-1:0] top_s;
    logic [STATE_W-1:0] next_state_s;
    logic               waiting_s;
    logic               cond_bit_s;
    logic               test_s;
    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic               illegal_s;
    logic               ovf_set_s;
    logic               unf_set_s;

    // Condition test, stall detect, increment and stack-top selection
    always_comb begin
        waiting_s  = mem_wait & ~moc;
        inc_s      = state_r + STATE_W'(1);
        full_s     = (depth_r == FULL_D);
        empty_s    = (depth_r == DEPTH_W'(0));
        // Only selector values below NUM_COND hit a flag; anything else reads 0.
        cond_bit_s = 1'b0;
        for (int i = 0; i < NUM_COND; i++) begin
            cond_bit_s = cond_bit_s | ((cond_sel == COND_SEL_W'(i)) & cond[i]);
        end
        test_s = cond_bit_s ^ cond_inv;
        // The top of stack lives at index depth-1; empty stack yields zero.
        top_s = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            top_s = top_s | ((depth_r == DEPTH_W'(i + 1)) ? stack_r[i] : '0);
        end
    end

    // Next-state selection, stack push/pop requests and fault detection
    always_comb begin
        next_state_s = state_r;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        illegal_s    = 1'b0;
        ovf_set_s    = 1'b0;
        unf_set_s    = 1'b0;
        if (waiting_s) begin
            // Stall: everything holds, no stack traffic.
            next_state_s = state_r;
        end else begin
            case (ns_mode)
                MODE_INC: begin
                    next_state_s = inc_s;
                end
                MODE_DISPATCH: begin
                    // The encoder reports unknown opcodes by pointing at fetch.
                    next_state_s = dispatch_state;
                    if (dispatch_state == FETCH_S) begin
                        illegal_s = 1'b1;
                    end else begin
                        illegal_s = 1'b0;
                    end
                end
                MODE_JUMP: begin
                    next_state_s = jump_state;
                end
                MODE_CJUMP: begin
                    if (test_s) begin
                        next_state_s = jump_state;
                    end else begin
                        next_state_s = inc_s;
                    end
                end
                MODE_FETCH: begin
                    next_state_s = FETCH_S;
                end
                MODE_CALL: begin
                    // The jump happens even when the return address is lost.
                    next_state_s = jump_state;
                    if (full_s) begin
                        ovf_set_s = 1'b1;
                    end else begin
                        push_s = 1'b1;
                    end
                end
                MODE_RET: begin
                    if (empty_s) begin
                        next_state_s = FETCH_S;
                        unf_set_s    = 1'b1;
                    end else begin
                        next_state_s = top_s;
                        pop_s        = 1'b1;
                    end
                end
                MODE_HOLD: begin
                    next_state_s = state_r;
                end
                default: begin
                    next_state_s = state_r;
                end
            endcase
        end
    end

    // State register, return stack, depth counter and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= RESET_S;
            depth_r   <= DEPTH_W'(0);
            illegal_r <= 1'b0;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_r[i] <= '0;
            end
        end else begin
            state_r   <= next_state_s;
            illegal_r <= illegal_s;
            ovf_r     <= ovf_r | ovf_set_s;
            unf_r     <= unf_r | unf_set_s;
            if (push_s) begin
                depth_r <= depth_r + DEPTH_W'(1);
            end else if (pop_s) begin
                depth_r <= depth_r - DEPTH_W'(1);
            end else begin
                depth_r <= depth_r;
            end
            // A push writes the slot just above the current top.
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (push_s && (depth_r == DEPTH_W'(i))) begin
                    stack_r[i] <= inc_s;
                end
            end
        end
    end

    // Output drive
    always_comb begin
        state       = state_r;
        stack_depth = depth_r;
        illegal_op  = illegal_r;
        stack_ovf   = ovf_r;
        stack_unf   = unf_r;
        waiting     = waiting_s;
    end

endmodule
